// File: rtl/aesl_deadlock_report_collector_pkg.sv
// ---------------------------------------------------------------------------
// aesl_deadlock_pkg
//   Shared types and constants for the deadlock report collector slice.
//   - dl_state_e  : collector FSM states (IDLE/ARMING/REPORT/HOLD)
//   - BLOCK_CODE_W: width of one axis channel's block code
//   - dl_report_t : report record {info, ts} at the default build widths
//   - infoWidth() : info bus width for a given number of axis channels
// ---------------------------------------------------------------------------
package aesl_deadlock_pkg;

  localparam int BLOCK_CODE_W = 2;
  localparam int DEF_NUM_AXIS = 2;
  localparam int DEF_TS_W     = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMING = 2'd1,
    REPORT = 2'd2,
    HOLD   = 2'd3
  } dl_state_e;

  typedef struct packed {
    logic [BLOCK_CODE_W*DEF_NUM_AXIS-1:0] info;
    logic [DEF_TS_W-1:0]                  ts;
  } dl_report_t;

  // Each axis channel contributes one block code to the info bus.
  function automatic int infoWidth(input int numAxis);
    return BLOCK_CODE_W * numAxis;
  endfunction

endpackage

// File: rtl/aesl_deadlock_report_collector_if.sv
// ---------------------------------------------------------------------------
// aesl_deadlock_report_collector_if
//   Bundles the monitor-facing inputs and the logger-facing report channel.
//   slave  : the collector (consumes block/info, sources the report)
//   master : the harness side (drives block/info/ready, sinks the report)
//   Signals:
//     block, axis_block_info  monitor block flag and per-channel codes
//     report_valid/ready      report handshake
//     report_info, report_ts  confirmed deadlock snapshot and window start
// ---------------------------------------------------------------------------
interface aesl_deadlock_report_collector_if #(
  parameter int NUM_AXIS = 2,
  parameter int TS_W     = 32
);
  import aesl_deadlock_pkg::*;

  localparam int INFO_W = infoWidth(NUM_AXIS);

  logic              block;
  logic [INFO_W-1:0] axis_block_info;
  logic              report_valid;
  logic              report_ready;
  logic [INFO_W-1:0] report_info;
  logic [TS_W-1:0]   report_ts;

  modport slave (
    input  block, axis_block_info, report_ready,
    output report_valid, report_info, report_ts
  );

  modport master (
    output block, axis_block_info, report_ready,
    input  report_valid, report_info, report_ts
  );

endinterface

// File: rtl/aesl_deadlock_report_collector_stable_window_counter.sv
// ---------------------------------------------------------------------------
// aesl_stable_window_counter
//   Tracks how long the current block pattern has been stable.
//   Ports:
//     clock, reset    clock and synchronous active-high reset
//     capture_i       start a fresh window on info_i / ts_i
//     count_i         blocked cycle inside an armed window
//     clear_i         drop the window count to zero
//     info_i, ts_i    current info pattern and timestamp
//     snapNext_o      pattern the window will hold after this cycle
//     t0Next_o        window start timestamp after this cycle
//     changed_o       info_i differs from the held pattern
//     reached_o       window length reaches THRESH this cycle
// ---------------------------------------------------------------------------
module aesl_stable_window_counter #(
  parameter int INFO_W = 4,
  parameter int TS_W   = 32,
  parameter int THRESH = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              capture_i,
  input  logic              count_i,
  input  logic              clear_i,
  input  logic [INFO_W-1:0] info_i,
  input  logic [TS_W-1:0]   ts_i,
  output logic [INFO_W-1:0] snapNext_o,
  output logic [TS_W-1:0]   t0Next_o,
  output logic              changed_o,
  output logic              reached_o
);

  // Wide enough to hold THRESH itself; the count saturates there.
  localparam int              CNT_W   = $clog2(THRESH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [INFO_W-1:0] snap_q, snap_d;
  logic [TS_W-1:0]   t0_q, t0_d;
  logic [CNT_W-1:0]  stableCnt_q, stableCnt_d;

  assign changed_o = (info_i != snap_q);

  // Next-window computation: a change of pattern inside an armed window
  // restarts the window exactly like an explicit capture does, so the
  // reported timestamp is always the first cycle of the final stable run.
  always_comb begin
    snap_d      = snap_q;
    t0_d        = t0_q;
    stableCnt_d = stableCnt_q;
    if (clear_i) begin
      stableCnt_d = '0;
    end else if (capture_i || (count_i && changed_o)) begin
      snap_d      = info_i;
      t0_d        = ts_i;
      stableCnt_d = CNT_ONE;
    end else if (count_i && (stableCnt_q != CNT_MAX)) begin
      stableCnt_d = stableCnt_q + CNT_ONE;
    end
  end

  assign reached_o  = (capture_i || count_i) && !clear_i && (stableCnt_d >= CNT_MAX);
  assign snapNext_o = snap_d;
  assign t0Next_o   = t0_d;

  // Window registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      snap_q      <= '0;
      t0_q        <= '0;
      stableCnt_q <= '0;
    end else begin
      snap_q      <= snap_d;
      t0_q        <= t0_d;
      stableCnt_q <= stableCnt_d;
    end
  end

endmodule

// File: rtl/aesl_deadlock_report_collector.sv
// ---------------------------------------------------------------------------
// aesl_deadlock_report_collector
//   Sink end of one deadlock monitor. Filters transient stalls: a report is
//   raised only once the same block pattern has persisted THRESH cycles,
//   and it is then timestamped and offered to the logger over valid/ready.
//   Ports:
//     clock, reset    clock and synchronous active-high reset
//     clear_sticky    one-cycle pulse clearing deadlock_seen
//     deadlock_seen   sticky: at least one report was raised
//     report_count    accepted reports, saturating
//     bus (slave)     block/axis_block_info in; report_valid/ready,
//                     report_info, report_ts
// ---------------------------------------------------------------------------
module aesl_deadlock_report_collector
  import aesl_deadlock_pkg::*;
#(
  parameter int NUM_AXIS = 2,
  parameter int THRESH   = 16,
  parameter int TS_W     = 32,
  parameter int CNT_W    = 8
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   clear_sticky,
  output logic                                   deadlock_seen,
  output logic [CNT_W-1:0]                       report_count,
  aesl_deadlock_report_collector_if.slave        bus
);

  localparam int               INFO_W  = infoWidth(NUM_AXIS);
  localparam logic [TS_W-1:0]  TS_ONE  = TS_W'(1);
  localparam logic [CNT_W-1:0] RC_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] RC_SAT  = '1;

  dl_state_e         state_q;
  logic [TS_W-1:0]   tsCnt_q;
  logic              reportValid_q;
  logic [INFO_W-1:0] reportInfo_q;
  logic [TS_W-1:0]   reportTs_q;
  logic              seen_q;
  logic [CNT_W-1:0]  reportCount_q;

  logic              capture;
  logic              count;
  logic              clear;
  logic              changed;
  logic              reached;
  logic              enterReport;
  logic [INFO_W-1:0] snapNext;
  logic [TS_W-1:0]   t0Next;

  // A window opens from IDLE on any block, or from HOLD when a different
  // pattern shows up (a new episode). While armed, every blocked cycle
  // counts; losing block abandons the window.
  assign capture     = bus.block && ((state_q == IDLE) || ((state_q == HOLD) && changed));
  assign count       = bus.block && (state_q == ARMING);
  assign clear       = !bus.block && ((state_q == ARMING) || (state_q == HOLD));
  assign enterReport = reached && ((state_q == IDLE) || (state_q == ARMING));

  aesl_stable_window_counter #(
    .INFO_W (INFO_W),
    .TS_W   (TS_W),
    .THRESH (THRESH)
  ) u_window (
    .clock      (clock),
    .reset      (reset),
    .capture_i  (capture),
    .count_i    (count),
    .clear_i    (clear),
    .info_i     (bus.axis_block_info),
    .ts_i       (tsCnt_q),
    .snapNext_o (snapNext),
    .t0Next_o   (t0Next),
    .changed_o  (changed),
    .reached_o  (reached)
  );

  // Collector FSM with registered outputs. The report payload is loaded on
  // REPORT entry and then frozen, so block/info activity during an
  // outstanding report cannot disturb it. A new-episode capture from HOLD
  // always goes through ARMING, even for a one-cycle threshold.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      tsCnt_q       <= '0;
      reportValid_q <= 1'b0;
      reportInfo_q  <= '0;
      reportTs_q    <= '0;
      seen_q        <= 1'b0;
      reportCount_q <= '0;
    end else begin
      tsCnt_q <= tsCnt_q + TS_ONE;

      case (state_q)
        IDLE: begin
          if (bus.block) begin
            state_q <= reached ? REPORT : ARMING;
          end
        end
        ARMING: begin
          if (!bus.block) begin
            state_q <= IDLE;
          end else if (reached) begin
            state_q <= REPORT;
          end
        end
        REPORT: begin
          if (bus.report_ready) begin
            state_q       <= HOLD;
            reportValid_q <= 1'b0;
            if (reportCount_q != RC_SAT) begin
              reportCount_q <= reportCount_q + RC_ONE;
            end
          end
        end
        HOLD: begin
          if (!bus.block) begin
            state_q <= IDLE;
          end else if (changed) begin
            state_q <= ARMING;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Setting the sticky flag takes priority over a coincident clear.
      if (enterReport) begin
        reportValid_q <= 1'b1;
        reportInfo_q  <= snapNext;
        reportTs_q    <= t0Next;
        seen_q        <= 1'b1;
      end else if (clear_sticky) begin
        seen_q <= 1'b0;
      end
    end
  end

  assign bus.report_valid = reportValid_q;
  assign bus.report_info  = reportInfo_q;
  assign bus.report_ts    = reportTs_q;
  assign deadlock_seen    = seen_q;
  assign report_count     = reportCount_q;

endmodule
